// File: rtl/dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dbus_arbiter
// Description : Two-master data bus arbiter. The CPU MEM stage owns the bus
//               by default; a DMA master borrows idle CPU cycles, and a
//               bounded wait counter forces a one-cycle CPU stall so the DMA
//               master cannot be starved.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_stall,
  input  logic        i_dma_req,
  input  logic        i_dma_wr,
  input  logic [31:0] i_dma_addr,
  input  logic [31:0] i_dma_wdata,
  output logic        o_dma_ack,
  output logic [31:0] o_dma_rdata,
  output logic        o_bus_rd,
  output logic        o_bus_wr,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] c_ONE      = WAIT_W'(1);

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_dma_ack;
  logic [31:0]         r_dma_rdata;

  logic w_cpu_act;
  logic w_cnt_full;
  logic w_steal;
  logic w_force;
  logic w_dma_on;

  // Grant decode: DMA takes idle CPU cycles, or forces once the wait budget is spent
  always_comb begin
    w_cpu_act  = i_cpu_rd | i_cpu_wr;
    w_cnt_full = (r_wait_cnt >= c_MAX_WAIT);
    w_steal    = 1'b0;
    w_force    = 1'b0;
    if (!reset && i_dma_req) begin
      if ((r_state == S_IDLE || r_state == S_WAIT) && !w_cpu_act) begin
        w_steal = 1'b1;
      end
      if (r_state == S_WAIT && w_cpu_act && w_cnt_full) begin
        w_force = 1'b1;
      end
    end
    w_dma_on = w_steal | w_force;
  end

  // Bus mux: CPU strobes never reach the bus while the DMA master owns it
  always_comb begin
    if (w_dma_on) begin
      o_bus_rd    = ~i_dma_wr;
      o_bus_wr    = i_dma_wr;
      o_bus_addr  = i_dma_addr;
      o_bus_wdata = i_dma_wdata;
    end else begin
      o_bus_rd    = i_cpu_rd;
      o_bus_wr    = i_cpu_wr;
      o_bus_addr  = i_cpu_addr;
      o_bus_wdata = i_cpu_wdata;
    end
  end

  assign o_cpu_rdata = i_bus_rdata;
  assign o_cpu_stall = w_force;
  assign o_dma_ack   = r_dma_ack;
  assign o_dma_rdata = r_dma_rdata;

  // Arbitration FSM, wait counter, ack pulse and captured DMA read data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_dma_ack   <= 1'b0;
      r_dma_rdata <= '0;
    end else begin
      r_dma_ack <= w_dma_on;
      if (w_dma_on && !i_dma_wr) begin
        r_dma_rdata <= i_bus_rdata;
      end
      case (r_state)
        S_IDLE: begin
          if (i_dma_req) begin
            if (!w_cpu_act) begin
              r_state <= S_ACK;
            end else begin
              r_wait_cnt <= c_ONE;
              r_state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!i_dma_req) begin
            // Request withdrawn before service: forget it
            r_wait_cnt <= '0;
            r_state    <= S_IDLE;
          end else if (!w_cpu_act || w_cnt_full) begin
            r_wait_cnt <= '0;
            r_state    <= S_ACK;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_ONE;
          end
        end
        S_ACK: begin
          // Request line is not sampled here; a held request restarts next cycle
          r_state <= S_IDLE;
        end
        default: begin
          r_wait_cnt <= '0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbus_arbiter
// Description : Cycle-table bench for dbus_arbiter with an expected-value
//               queue, plus a hand-written starvation latency sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_wr;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic        bus_rd, bus_wr;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  dbus_arbiter #(.MAX_WAIT(4), .WAIT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_cpu_rd   (cpu_rd),
    .i_cpu_wr   (cpu_wr),
    .i_cpu_addr (cpu_addr),
    .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata),
    .o_cpu_stall(cpu_stall),
    .i_dma_req  (dma_req),
    .i_dma_wr   (dma_wr),
    .i_dma_addr (dma_addr),
    .i_dma_wdata(dma_wdata),
    .o_dma_ack  (dma_ack),
    .o_dma_rdata(dma_rdata),
    .o_bus_rd   (bus_rd),
    .o_bus_wr   (bus_wr),
    .o_bus_addr (bus_addr),
    .o_bus_wdata(bus_wdata),
    .i_bus_rdata(bus_rdata)
  );

  typedef struct {
    string       name;
    logic        rst, crd, cwr, dreq, dwr;
    logic [31:0] daddr, dwd, brd;
    logic        e_dma, e_stall, e_ack;
    logic [31:0] e_drd;
  } vec_t;

  typedef struct {
    string       name;
    logic        bus_rd, bus_wr, stall, ack;
    logic [31:0] bus_addr, bus_wdata, drd, crd;
  } exp_t;

  vec_t vecs[$];
  exp_t expq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(string nm, logic rst, logic crd, logic cwr,
                              logic dreq, logic dwr, logic [31:0] daddr,
                              logic [31:0] dwd, logic [31:0] brd, logic e_dma,
                              logic e_stall, logic e_ack, logic [31:0] e_drd);
    vec_t v;
    v.name = nm; v.rst = rst; v.crd = crd; v.cwr = cwr; v.dreq = dreq;
    v.dwr = dwr; v.daddr = daddr; v.dwd = dwd; v.brd = brd; v.e_dma = e_dma;
    v.e_stall = e_stall; v.e_ack = e_ack; v.e_drd = e_drd;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Drive one table row for a whole cycle and queue its expected outputs
  task automatic drive_row(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    reset     = v.rst;
    cpu_rd    = v.crd;
    cpu_wr    = v.cwr;
    cpu_addr  = 32'h0000_1000 + 32'(idx * 4);
    cpu_wdata = 32'hC0DE_0000 + 32'(idx);
    dma_req   = v.dreq;
    dma_wr    = v.dwr;
    dma_addr  = v.daddr;
    dma_wdata = v.dwd;
    bus_rdata = v.brd;
    e.name  = v.name;
    if (v.e_dma) begin
      e.bus_rd = ~v.dwr; e.bus_wr = v.dwr;
      e.bus_addr = v.daddr; e.bus_wdata = v.dwd;
    end else begin
      e.bus_rd = v.crd; e.bus_wr = v.cwr;
      e.bus_addr = cpu_addr; e.bus_wdata = cpu_wdata;
    end
    e.stall = v.e_stall;
    e.ack   = v.e_ack;
    e.drd   = v.e_drd;
    e.crd   = v.brd;
    expq.push_back(e);
  endtask

  task automatic check_row();
    exp_t e;
    e = expq.pop_front();
    chk({e.name, ".bus_rd"},    32'(bus_rd),    32'(e.bus_rd));
    chk({e.name, ".bus_wr"},    32'(bus_wr),    32'(e.bus_wr));
    chk({e.name, ".bus_addr"},  bus_addr,       e.bus_addr);
    chk({e.name, ".bus_wdata"}, bus_wdata,      e.bus_wdata);
    chk({e.name, ".cpu_stall"}, 32'(cpu_stall), 32'(e.stall));
    chk({e.name, ".dma_ack"},   32'(dma_ack),   32'(e.ack));
    chk({e.name, ".dma_rdata"}, dma_rdata,      e.drd);
    chk({e.name, ".cpu_rdata"}, cpu_rdata,      e.crd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc, ack_cyc, stalls;
    localparam logic [31:0] Z = 32'h0;
    localparam logic [31:0] JUNK = 32'h0BAD_F00D;
    localparam logic [31:0] FA = 32'h4000_0010;

    reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_wdata = '0; bus_rdata = '0;
    repeat (2) @(posedge clk);

    //                name   rst crd cwr req wr daddr      dwd       brd           dma stl ack drd
    vecs.push_back(mk("rst0", 1, 1, 0, 1, 0, 32'h40,     Z,        32'h11,        0, 0, 0, Z));
    vecs.push_back(mk("rst1", 1, 1, 0, 1, 0, 32'h40,     Z,        32'h22,        0, 0, 0, Z));
    vecs.push_back(mk("idl0", 0, 0, 0, 0, 0, Z,          Z,        JUNK,          0, 0, 0, Z));
    vecs.push_back(mk("stl0", 0, 0, 0, 1, 0, 32'h40,     Z,        32'h12345678,  1, 0, 0, Z));
    vecs.push_back(mk("stl1", 0, 0, 0, 0, 0, Z,          Z,        Z,             0, 0, 1, 32'h12345678));
    vecs.push_back(mk("stl2", 0, 0, 0, 0, 0, Z,          Z,        JUNK,          0, 0, 0, 32'h12345678));
    vecs.push_back(mk("frc0", 0, 0, 1, 1, 1, FA,         32'hA5,   JUNK,          0, 0, 0, 32'h12345678));
    vecs.push_back(mk("frc1", 0, 0, 1, 1, 1, FA,         32'hA5,   JUNK,          0, 0, 0, 32'h12345678));
    vecs.push_back(mk("frc2", 0, 0, 1, 1, 1, FA,         32'hA5,   JUNK,          0, 0, 0, 32'h12345678));
    vecs.push_back(mk("frc3", 0, 0, 1, 1, 1, FA,         32'hA5,   JUNK,          0, 0, 0, 32'h12345678));
    vecs.push_back(mk("frc4", 0, 0, 1, 1, 1, FA,         32'hA5,   JUNK,          1, 1, 0, 32'h12345678));
    vecs.push_back(mk("frc5", 0, 0, 1, 0, 0, Z,          Z,        JUNK,          0, 0, 1, 32'h12345678));
    vecs.push_back(mk("frc6", 0, 0, 1, 0, 0, Z,          Z,        JUNK,          0, 0, 0, 32'h12345678));
    vecs.push_back(mk("b2b0", 0, 0, 0, 1, 0, 32'h80,     Z,        32'hA0,        1, 0, 0, 32'h12345678));
    vecs.push_back(mk("b2b1", 0, 0, 0, 1, 0, 32'h80,     Z,        32'hB1,        0, 0, 1, 32'hA0));
    vecs.push_back(mk("b2b2", 0, 0, 0, 1, 0, 32'h80,     Z,        32'hA2,        1, 0, 0, 32'hA0));
    vecs.push_back(mk("b2b3", 0, 0, 0, 1, 0, 32'h80,     Z,        32'hB3,        0, 0, 1, 32'hA2));
    vecs.push_back(mk("b2b4", 0, 0, 0, 1, 0, 32'h80,     Z,        32'hA4,        1, 0, 0, 32'hA2));
    vecs.push_back(mk("b2b5", 0, 0, 0, 0, 0, Z,          Z,        32'hB5,        0, 0, 1, 32'hA4));
    vecs.push_back(mk("abt0", 0, 1, 0, 1, 0, 32'h50,     Z,        JUNK,          0, 0, 0, 32'hA4));
    vecs.push_back(mk("abt1", 0, 1, 0, 1, 0, 32'h50,     Z,        JUNK,          0, 0, 0, 32'hA4));
    vecs.push_back(mk("abt2", 0, 1, 0, 0, 0, Z,          Z,        JUNK,          0, 0, 0, 32'hA4));
    vecs.push_back(mk("abt3", 0, 1, 0, 1, 0, 32'h54,     Z,        JUNK,          0, 0, 0, 32'hA4));
    vecs.push_back(mk("abt4", 0, 1, 0, 1, 0, 32'h54,     Z,        JUNK,          0, 0, 0, 32'hA4));
    vecs.push_back(mk("abt5", 0, 1, 0, 1, 0, 32'h54,     Z,        JUNK,          0, 0, 0, 32'hA4));
    vecs.push_back(mk("abt6", 0, 1, 0, 1, 0, 32'h54,     Z,        JUNK,          0, 0, 0, 32'hA4));
    vecs.push_back(mk("abt7", 0, 1, 0, 1, 0, 32'h54,     Z,        32'h5555AAAA,  1, 1, 0, 32'hA4));
    vecs.push_back(mk("abt8", 0, 1, 0, 0, 0, Z,          Z,        JUNK,          0, 0, 1, 32'h5555AAAA));
    vecs.push_back(mk("wst0", 0, 1, 0, 1, 1, 32'h60,     32'h77,   JUNK,          0, 0, 0, 32'h5555AAAA));
    vecs.push_back(mk("wst1", 0, 0, 0, 1, 1, 32'h60,     32'h77,   JUNK,          1, 0, 0, 32'h5555AAAA));
    vecs.push_back(mk("wst2", 0, 0, 0, 0, 0, Z,          Z,        JUNK,          0, 0, 1, 32'h5555AAAA));
    vecs.push_back(mk("mrs0", 0, 1, 0, 1, 1, 32'h70,     32'h99,   JUNK,          0, 0, 0, 32'h5555AAAA));
    vecs.push_back(mk("mrs1", 0, 1, 0, 1, 1, 32'h70,     32'h99,   JUNK,          0, 0, 0, 32'h5555AAAA));
    vecs.push_back(mk("mrs2", 0, 1, 0, 1, 1, 32'h70,     32'h99,   JUNK,          0, 0, 0, 32'h5555AAAA));
    vecs.push_back(mk("mrs3", 1, 1, 0, 1, 1, 32'h70,     32'h99,   JUNK,          0, 0, 0, 32'h5555AAAA));
    vecs.push_back(mk("mrs4", 0, 1, 0, 1, 1, 32'h70,     32'h99,   JUNK,          0, 0, 0, Z));
    vecs.push_back(mk("mrs5", 0, 1, 0, 1, 1, 32'h70,     32'h99,   JUNK,          0, 0, 0, Z));
    vecs.push_back(mk("mrs6", 0, 1, 0, 1, 1, 32'h70,     32'h99,   JUNK,          0, 0, 0, Z));
    vecs.push_back(mk("mrs7", 0, 1, 0, 1, 1, 32'h70,     32'h99,   JUNK,          0, 0, 0, Z));
    vecs.push_back(mk("mrs8", 0, 1, 0, 1, 1, 32'h70,     32'h99,   JUNK,          1, 1, 0, Z));
    vecs.push_back(mk("mrs9", 0, 1, 0, 0, 0, Z,          Z,        JUNK,          0, 0, 1, Z));

    foreach (vecs[i]) begin
      drive_row(vecs[i], i);
      #1;
      check_row();
    end

    // Starvation latency: CPU writes every cycle, DMA write must land after MAX_WAIT+1 cycles
    acc_cyc = -1; ack_cyc = -1; stalls = 0;
    for (int c = 0; c < 20 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 0) begin
        reset = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b1;
        cpu_addr = 32'h2000; cpu_wdata = 32'h1111;
        dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'h90; dma_wdata = 32'hBEEF;
        bus_rdata = JUNK;
      end else if (acc_cyc >= 0) begin
        dma_req = 1'b0;
      end
      #1;
      if (cpu_stall === 1'b1) stalls++;
      if (bus_wr === 1'b1 && bus_addr === 32'h90 && acc_cyc < 0) acc_cyc = c;
      if (dma_ack === 1'b1) ack_cyc = c;
    end
    chk("lat.access_cycle", 32'(acc_cyc), 32'd4);
    chk("lat.ack_cycle",    32'(ack_cyc), 32'd5);
    chk("lat.stall_count",  32'(stalls),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
